barrido_tabla: RTL and testbench
================================

# barrido_tabla

- Self-checking truth-table sweeper for the lab's small combinational blocks (3- and 4-input truth-table and formula modules).
- Sits directly upstream of the block under test: drives every input combination in ascending order, waits a settle interval, and samples the block's single output.
- Compares each sample against an expected truth-table column and reports the captured column, a mismatch count and pass/fail.
- Replaces hand-written per-table stimulus sequences with one reusable clocked stage.

## Interface
- `N_IN`, 4: number of inputs to the block under test, 1..6.
- `SETTLE`, 1: cycles each vector is held before sampling, ≥1.
- `EXPECTED`, all zeros: expected output column, `2**N_IN` bits; bit i is the expected Y for input vector i.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sweep request, sampled only in IDLE.
- `dut_y`  in  1  output of the block under test.
- `vec`  out  N_IN  applied input vector, MSB = first input (A).
- `busy`  out  1  high while sweeping (APPLY/SAMPLE).
- `done`  out  1  one-cycle pulse at end of sweep.
- `result`  out  2**N_IN  captured output column; bit i = dut_y sampled for vec = i.
- `err_count`  out  N_IN+1  number of mismatching vectors.
- `pass`  out  1  high when the last sweep had err_count = 0.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- **IDLE.** On `start`=1, go to APPLY and, in the same edge:
  - vec←0
  - settle counter←0
  - result←0
  - err_count←0
  - pass←0
- **APPLY.** Settle counter increments each cycle. On the edge where the counter equals SETTLE−1, go to SAMPLE. APPLY therefore lasts SETTLE cycles.
- **SAMPLE.** On the edge:
  - result[vec]←dut_y
  - if dut_y ≠ EXPECTED[vec], err_count increments
  - if vec = 2**N_IN−1, go to DONE; otherwise vec←vec+1, counter←0, go to APPLY
- **DONE.** Lasts one cycle. pass←(err_count = 0), evaluated using the final count. Then returns to IDLE.
- Outputs: busy=1 in APPLY/SAMPLE only; done=1 in DONE only.
- Holding after a sweep: vec, result, err_count and pass hold their values until the next accepted start.
- Width: err_count maximum is 2**N_IN, which fits in N_IN+1 bits, so no saturation is needed. vec never wraps; the sweep ends at all-ones.
- `start` while busy or in DONE: ignored, not queued.

## Timing
- Reset values (asynchronous, immediate): state IDLE, vec=0, busy=0, done=0, result=0, err_count=0, pass=0.
- Reset mid-sweep: aborts the sweep and forces reset values; no partial results are retained.
- Each vector occupies SETTLE+1 cycles (SETTLE APPLY + 1 SAMPLE).
- dut_y is sampled SETTLE+1 edges after vec changes.
- Counting from the edge that accepts `start`:
  - done is high during cycle 2**N_IN·(SETTLE+1)
  - busy is high for exactly 2**N_IN·(SETTLE+1) cycles
- Earliest next accepted start: the cycle after done, back in IDLE.
- Ordering: result and err_count are final in the cycle done is high. pass becomes valid the cycle after done (registered in DONE).

## Configuration
- Macro: `BARRIDO_STOP_ON_ERROR_EN`.
- Defined:
  - a mismatch in SAMPLE goes straight to DONE
  - vec holds the failing vector, err_count=1, pass=0
  - result contains bits captured up to and including the failing vector
- Undefined: every sweep covers all 2**N_IN vectors regardless of mismatches.

## Test plan
Benches use N_IN=3, SETTLE=2, EXPECTED=8'h96 (3-input XOR) unless stated.
- Reset asserted, no start → vec=0, busy=0, done=0, result=0, err_count=0, pass=0; idle indefinitely.
- XOR3 model on dut_y, 1-cycle start:
  - vec steps 0..7, each held 3 cycles
  - done pulses 24 cycles after the accepting edge
  - result=8'h96, err_count=0, pass=1 the following cycle
- dut_y tied 0:
  - result=8'h00, err_count=4, pass=0
  - with N_IN=4, EXPECTED=16'hFFFF and dut_y tied 0: err_count=16 (5'b10000), no overflow
- start pulsed at vec=3 mid-sweep and again in the DONE cycle → both ignored; sweep timing unchanged. A start one cycle after done → new sweep begins and result is cleared.
- rst_n low for 1 cycle at vec=4 → all outputs to reset values immediately. A subsequent start completes a full correct sweep (result=8'h96).
- With `BARRIDO_STOP_ON_ERROR_EN` and XOR3 with output inverted at vec=5 → done after 18 cycles, vec=5, err_count=1, pass=0, result=8'h36. Same stimulus without the macro → err_count=1, result=8'hB6, done at cycle 24.

Source files
------------

// File: rtl/barrido_tabla.sv
// Truth-table sweeper: drives every input vector in ascending order, samples the block's
// output after a settle interval and compares it with EXPECTED. Option: BARRIDO_STOP_ON_ERROR_EN.
module barrido_tabla #(
   parameter int                      N_IN     = 4,
   parameter int                      SETTLE   = 1,
   parameter logic [(1<<N_IN)-1:0]    EXPECTED = {(1<<N_IN){1'b0}}
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   dut_y,
   output logic [N_IN-1:0]        vec,
   output logic                   busy,
   output logic                   done,
   output logic [(1<<N_IN)-1:0]   result,
   output logic [N_IN:0]          err_count,
   output logic                   pass
);

   localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                 state_r;
   state_t                 state_s;
   logic [CW-1:0]          cnt_r;
   logic [N_IN-1:0]        vec_r;
   logic [(1<<N_IN)-1:0]   result_r;
   logic [N_IN:0]          err_r;
   logic                   pass_r;
   logic                   busy_r;
   logic                   done_r;
   logic                   mismatch_s;

   assign mismatch_s = (dut_y != EXPECTED[vec_r]);

   // Next-state decode of the sweep sequencer
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_s = APPLY;
            else       state_s = IDLE;
         end
         APPLY: begin
            if (cnt_r == CNT_LAST) state_s = SAMPLE;
            else                   state_s = APPLY;
         end
         SAMPLE: begin
`ifdef BARRIDO_STOP_ON_ERROR_EN
            if (mismatch_s || (vec_r == VEC_LAST)) state_s = DONE;
            else                                   state_s = APPLY;
`else
            if (vec_r == VEC_LAST) state_s = DONE;
            else                   state_s = APPLY;
`endif
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register and registered status strobes, decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == APPLY) || (state_s == SAMPLE);
         done_r  <= (state_s == DONE);
      end
   end

   // Sweep datapath: vector, settle counter, captured column, mismatch count, verdict
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= {CW{1'b0}};
         vec_r    <= {N_IN{1'b0}};
         result_r <= {(1<<N_IN){1'b0}};
         err_r    <= {(N_IN+1){1'b0}};
         pass_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  cnt_r    <= {CW{1'b0}};
                  vec_r    <= {N_IN{1'b0}};
                  result_r <= {(1<<N_IN){1'b0}};
                  err_r    <= {(N_IN+1){1'b0}};
                  pass_r   <= 1'b0;
               end
            end
            APPLY: begin
               if (cnt_r != CNT_LAST) cnt_r <= cnt_r + CW'(1);
            end
            SAMPLE: begin
               result_r[vec_r] <= dut_y;
               if (mismatch_s) err_r <= err_r + (N_IN+1)'(1);
               // Only advance when another vector follows; a finished sweep keeps its last vector
               if (state_s == APPLY) begin
                  vec_r <= vec_r + N_IN'(1);
                  cnt_r <= {CW{1'b0}};
               end
            end
            DONE: begin
               pass_r <= (err_r == {(N_IN+1){1'b0}});
            end
            default: begin
               cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   assign vec       = vec_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign result    = result_r;
   assign err_count = err_r;
   assign pass      = pass_r;

endmodule

// File: tb/tb_barrido_tabla.sv
// Directed bench for barrido_tabla: XOR3 sweeps, tied-low output, ignored starts,
// mid-sweep reset, a single-vector fault and a 4-input all-ones expectation.
module tb_barrido_tabla;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        start4 = 1'b0;
   logic        dut_y;
   int          mode = 0;
   int          passed = 0;
   int          failed = 0;
   int          total = 0;
   int          dc, bc, vb;

   logic [2:0]  vec;
   logic        busy, done, pass;
   logic [7:0]  result;
   logic [3:0]  err_count;

   logic [3:0]  vec4;
   logic        busy4, done4, pass4;
   logic [15:0] result4;
   logic [4:0]  err4;

   always #5 clk = ~clk;

   // Stand-in for the block under test: XOR3, tied low, or XOR3 wrong only at vector 5
   always_comb begin
      if (mode == 1)      dut_y = 1'b0;
      else if (mode == 2) dut_y = (^vec) ^ (vec == 3'd5);
      else                dut_y = ^vec;
   end

   barrido_tabla #(.N_IN(3), .SETTLE(2), .EXPECTED(8'h96)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_y(dut_y),
      .vec(vec), .busy(busy), .done(done), .result(result),
      .err_count(err_count), .pass(pass)
   );

   barrido_tabla #(.N_IN(4), .SETTLE(2), .EXPECTED(16'hFFFF)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .dut_y(1'b0),
      .vec(vec4), .busy(busy4), .done(done4), .result(result4),
      .err_count(err4), .pass(pass4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge of cycle 0 of the sweep
   task automatic kick();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // From cycle 0, waits for done; reports its cycle, busy cycles and vector-schedule errors
   task automatic wait_done(input bit inj, output int dcyc, output int bcyc, output int vbad);
      dcyc = 0;
      bcyc = 0;
      vbad = 0;
      while (!done && dcyc < 300) begin
         if (busy) bcyc++;
         if (dcyc < 24 && vec !== 3'(dcyc / 3)) vbad++;
         start = inj && (dcyc == 9);
         @(negedge clk);
         dcyc++;
      end
      start = 1'b0;
   endtask

   initial begin
      // Reset and idle
      repeat (3) @(negedge clk);
      chk("rst_vec", vec, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_err", err_count, 0);
      chk("rst_pass", pass, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_vec", vec, 0);

      // Correct XOR3 sweep
      mode = 0;
      kick();
      wait_done(1'b0, dc, bc, vb);
      chk("xor_done_cycle", dc, 24);
      chk("xor_busy_cycles", bc, 24);
      chk("xor_vec_steps", vb, 0);
      chk("xor_result", result, 8'h96);
      chk("xor_err", err_count, 0);
      chk("xor_busy_in_done", busy, 0);
      @(negedge clk);
      chk("xor_pass", pass, 1);
      chk("xor_done_low", done, 0);

      // Output tied low
      mode = 1;
      kick();
      wait_done(1'b0, dc, bc, vb);
      chk("zero_done_cycle", dc, 24);
      chk("zero_result", result, 8'h00);
      chk("zero_err", err_count, 4);
      @(negedge clk);
      chk("zero_pass", pass, 0);

      // start mid-sweep and in DONE ignored; start right after DONE accepted
      mode = 0;
      kick();
      wait_done(1'b1, dc, bc, vb);
      chk("ign_done_cycle", dc, 24);
      chk("ign_busy_cycles", bc, 24);
      chk("ign_vec_steps", vb, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_idle_busy", busy, 0);
      chk("ign_pass", pass, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_busy", busy, 1);
      chk("restart_result_clr", result, 0);
      chk("restart_err_clr", err_count, 0);
      chk("restart_pass_clr", pass, 0);
      wait_done(1'b0, dc, bc, vb);
      chk("restart_done_cycle", dc, 24);
      chk("restart_result", result, 8'h96);

      // Reset pulse at vec=4
      @(negedge clk);
      kick();
      repeat (12) @(negedge clk);
      chk("mid_vec_before", vec, 4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vec", vec, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_err", err_count, 0);
      chk("mid_rst_pass", pass, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      kick();
      wait_done(1'b0, dc, bc, vb);
      chk("post_rst_done_cycle", dc, 24);
      chk("post_rst_result", result, 8'h96);
      chk("post_rst_err", err_count, 0);
      @(negedge clk);

      // Single wrong vector at 5
      mode = 2;
      kick();
      wait_done(1'b0, dc, bc, vb);
`ifdef BARRIDO_STOP_ON_ERROR_EN
      chk("fault_done_cycle", dc, 18);
      chk("fault_vec", vec, 5);
      chk("fault_result", result, 8'h36);
`else
      chk("fault_done_cycle", dc, 24);
      chk("fault_vec", vec, 7);
      chk("fault_result", result, 8'hB6);
`endif
      chk("fault_err", err_count, 1);
      @(negedge clk);
      chk("fault_pass", pass, 0);
      mode = 0;

      // Four inputs, all-ones expectation, output tied low
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      dc = 0;
      while (!done4 && dc < 300) begin
         @(negedge clk);
         dc++;
      end
`ifdef BARRIDO_STOP_ON_ERROR_EN
      chk("n4_done_cycle", dc, 3);
      chk("n4_err", err4, 5'd1);
      chk("n4_vec", vec4, 0);
`else
      chk("n4_done_cycle", dc, 48);
      chk("n4_err", err4, 5'b10000);
      chk("n4_vec", vec4, 15);
`endif
      chk("n4_result", result4, 16'h0000);
      @(negedge clk);
      chk("n4_pass", pass4, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
